// File: rtl/cf_fft_pkg.sv
// Shared definitions for the cf_fft pipeline: read-order encodings and a
// width-parametrised bit-reversal helper.
package cf_fft_pkg;

    localparam logic ORDER_NATURAL = 1'b0;
    localparam logic ORDER_BITREV  = 1'b1;

    // Reverses the low 'width' bits of val; bits at or above width come back as 0.
    function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
        logic [31:0] res;
        res = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res[i] = val[width - 1 - i];
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cf_fft_pp_bank.sv
// One DEPTH x DATA_W sample bank: synchronous write port and a registered
// read port, each with its own enable.
module cf_fft_pp_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // Sample storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; the output register clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cf_fft_reorder_pp.sv
// Ping-pong reorder buffer: one bank fills by random address while the other
// drains in natural or bit-reversed order, with frame-length checking.
module cf_fft_reorder_pp
    import cf_fft_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clock_c,
    input  logic              reset_n_c,
    input  logic              en,
    input  logic              frame_start,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bitrev,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_first,
    output logic              frame_start_out,
    output logic              frame_err
);

    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_MAX   = {(ADDR_W+1){1'b1}};

    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic              r_mode_q;
    logic              r_seen;
    logic              r_full;
    logic [ADDR_W:0]   r_wr_cnt;
    logic              r_frame_err;
    logic              r_rd_first;
    logic              r_fso;
    logic              r_rd_sel;

    logic              w_wb;
    logic              w_rb;
    logic              w_active;
    logic [ADDR_W-1:0] w_idx;
    logic              w_mode;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W:0]   w_wr_cnt_nxt;
    logic              w_err_nxt;
    logic [DATA_W-1:0] w_q0;
    logic [DATA_W-1:0] w_q1;

    // Bank steering, read index/address generation and frame-length check.
    always_comb begin
        w_wb         = r_wr_bank ^ frame_start;
        w_rb         = ~w_wb;
        w_active     = r_seen | frame_start;
        w_idx        = r_rd_cnt + ADDR_W'(1'b1);
        w_mode       = r_mode_q;
        w_rd_addr    = w_idx;
        w_wr_cnt_nxt = r_wr_cnt;
        w_err_nxt    = r_frame_err;

        if (frame_start) begin
            w_idx  = '0;
            w_mode = rd_bitrev;
        end else begin
            w_idx  = r_rd_cnt + ADDR_W'(1'b1);
            w_mode = r_mode_q;
        end

        if (w_mode == ORDER_BITREV) begin
            w_rd_addr = ADDR_W'(bitrev(32'(w_idx), ADDR_W));
        end else begin
            w_rd_addr = w_idx;
        end

        // The count saturates so a grossly overlong frame cannot alias back to DEPTH.
        if (frame_start) begin
            w_wr_cnt_nxt = {{ADDR_W{1'b0}}, wr_valid};
            if (r_seen && (r_wr_cnt != DEPTH_CNT)) begin
                w_err_nxt = 1'b1;
            end else begin
                w_err_nxt = r_frame_err;
            end
        end else if (wr_valid && (r_wr_cnt != CNT_MAX)) begin
            w_wr_cnt_nxt = r_wr_cnt + (ADDR_W+1)'(1'b1);
        end else begin
            w_wr_cnt_nxt = r_wr_cnt;
        end
    end

    // Control state; everything holds while en is low.
    always_ff @(posedge clock_c or negedge reset_n_c) begin
        if (!reset_n_c) begin
            r_wr_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_mode_q    <= ORDER_NATURAL;
            r_seen      <= 1'b0;
            r_full      <= 1'b0;
            r_wr_cnt    <= '0;
            r_frame_err <= 1'b0;
            r_rd_first  <= 1'b0;
            r_fso       <= 1'b0;
            r_rd_sel    <= 1'b0;
        end else if (en) begin
            r_wr_bank   <= w_wb;
            r_rd_cnt    <= w_idx;
            r_seen      <= r_seen | frame_start;
            r_full      <= r_full | (frame_start & r_seen);
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_frame_err <= w_err_nxt;
            r_rd_first  <= w_active & (w_idx == '0);
            r_fso       <= frame_start;
            if (frame_start) begin
                r_mode_q <= rd_bitrev;
            end
            // Before the first frame nothing is read, keeping the outputs at zero.
            if (w_active) begin
                r_rd_sel <= w_rb;
            end
        end
    end

    cf_fft_pp_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
        .clk       (clock_c),
        .rst_n     (reset_n_c),
        .i_wr_en   (en & wr_valid & (w_wb == 1'b0)),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (en & w_active & (w_rb == 1'b0)),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_q0)
    );

    cf_fft_pp_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
        .clk       (clock_c),
        .rst_n     (reset_n_c),
        .i_wr_en   (en & wr_valid & (w_wb == 1'b1)),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (en & w_active & (w_rb == 1'b1)),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_q1)
    );

    assign rd_data         = r_rd_sel ? w_q1 : w_q0;
    assign rd_valid        = r_full;
    assign rd_first        = r_rd_first;
    assign frame_start_out = r_fso;
    assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_cf_fft_reorder_pp.sv
// Directed scoreboard bench for cf_fft_reorder_pp with DATA_W=32, ADDR_W=3.
module tb_cf_fft_reorder_pp;

    logic        clock_c = 1'b0;
    logic        reset_n_c;
    logic        en;
    logic        frame_start;
    logic        wr_valid;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_bitrev;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_first;
    logic        frame_start_out;
    logic        frame_err;

    typedef struct packed {
        logic [31:0] d;
        logic        f;
        logic        s;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   br_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    cf_fft_reorder_pp #(.DATA_W(32), .ADDR_W(3)) dut (
        .clock_c         (clock_c),
        .reset_n_c       (reset_n_c),
        .en              (en),
        .frame_start     (frame_start),
        .wr_valid        (wr_valid),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rd_bitrev       (rd_bitrev),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_first        (rd_first),
        .frame_start_out (frame_start_out),
        .frame_err       (frame_err)
    );

    always #5 clock_c = ~clock_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_data"}, rd_data, 32'd0);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_first"}, 32'(rd_first), 32'd0);
        chk({tag, "_fso"}, 32'(frame_start_out), 32'd0);
        chk({tag, "_err"}, 32'(frame_err), 32'd0);
    endtask

    task automatic step(input logic fs, input logic br, input logic wv,
                        input logic [2:0] a, input logic [31:0] d, input logic e);
        frame_start = fs;
        rd_bitrev   = br;
        wr_valid    = wv;
        wr_addr     = a;
        wr_data     = d;
        en          = e;
        @(posedge clock_c);
        #1;
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
            zero_check(tag);
        end
    endtask

    task automatic cmp_item(input exp_t e, input string tag);
        chk({tag, "_data"}, rd_data, e.d);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_first"}, 32'(rd_first), 32'(e.f));
        chk({tag, "_fso"}, 32'(frame_start_out), 32'(e.s));
    endtask

    // One 8-sample frame: frame_start on k=0, optional writes of wbase+k,
    // optional read-out check of ebase in natural or bit-reversed order.
    task automatic run_frame(input logic br, input logic do_wr, input logic [31:0] wbase,
                             input logic do_chk, input logic [31:0] ebase,
                             input logic ebr, input logic stall, input string tag);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            if (do_chk) begin
                e.d = ebase + (ebr ? 32'(br_tab[k]) : 32'(k));
                e.f = (k == 0);
                e.s = (k == 0);
                sb.push_back(e);
            end
            step((k == 0), br, do_wr, 3'(k), wbase + 32'(k), 1'b1);
            if (do_chk) begin
                e = sb.pop_front();
                cmp_item(e, tag);
                if (stall && (k == 3)) begin
                    for (int s = 0; s < 3; s++) begin
                        step(1'b1, 1'b1, 1'b1, 3'd2, 32'hDEAD_0000, 1'b0);
                        e.f = 1'b0;
                        e.s = 1'b0;
                        cmp_item(e, {tag, "_hold"});
                    end
                end
            end else begin
                chk({tag, "_novalid"}, 32'(rd_valid), 32'd0);
            end
        end
    endtask

    initial begin
        reset_n_c   = 1'b0;
        en          = 1'b0;
        frame_start = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = 3'd0;
        wr_data     = 32'd0;
        rd_bitrev   = 1'b0;
        #3;
        zero_check("rst0");
        @(posedge clock_c);
        #2;
        reset_n_c = 1'b1;
        idle_check(10, "idle0");

        run_frame(1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, "fillA");
        run_frame(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, "natA");
        run_frame(1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 1'b0, "revA");
        run_frame(1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, "natB");
        run_frame(1'b0, 1'b1, 32'h300, 1'b1, 32'h100, 1'b0, 1'b1, "stallA");
        run_frame(1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 1'b0, "natC");
        chk("full_frames_err", 32'(frame_err), 32'd0);

        // Asynchronous reset asserted between clock edges.
        #2;
        reset_n_c = 1'b0;
        #1;
        zero_check("rst_mid");
        @(posedge clock_c);
        #2;
        reset_n_c = 1'b1;
        idle_check(10, "idle1");

        // Short frame of 5 writes.
        step(1'b1, 1'b0, 1'b1, 3'd0, 32'h400, 1'b1);
        chk("short_p1_valid", 32'(rd_valid), 32'd0);
        chk("short_p1_err", 32'(frame_err), 32'd0);
        for (int k = 1; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 3'(k), 32'h400 + 32'(k), 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        chk("short_err", 32'(frame_err), 32'd1);
        chk("short_p2_valid", 32'(rd_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
            chk("short_err_sticky", 32'(frame_err), 32'd1);
        end

        #2;
        reset_n_c = 1'b0;
        #1;
        chk("rst2_err", 32'(frame_err), 32'd0);
        chk("rst2_valid", 32'(rd_valid), 32'd0);
        @(posedge clock_c);
        #2;
        reset_n_c = 1'b1;
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        chk("b2b_p1_valid", 32'(rd_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        chk("b2b_p2_valid", 32'(rd_valid), 32'd1);
        chk("b2b_err", 32'(frame_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cf_fft_reorder_pp.md
Name: cf_fft_reorder_pp

Overview:
Parametrised double-buffered (ping-pong) sample reorder buffer for the cf_fft pipeline.
- One bank is written by random address while the other is read out sequentially.
- Read order is natural or bit-reversed, selectable per frame.
- Adds frame-length checking and an output-valid qualifier, so downstream stages know when the read stream carries real data.

Parameters:
DATA_W, 32, sample width in bits
ADDR_W, 8, bank address width; DEPTH = 2**ADDR_W samples per frame

Ports:
clock_c  in  1  system clock, rising edge
reset_n_c  in  1  asynchronous active-low reset
en  in  1  clock enable; all state holds when 0
frame_start  in  1  sync pulse; marks the first sample of a new frame
wr_valid  in  1  write strobe
wr_addr  in  ADDR_W  write address within the current frame
wr_data  in  DATA_W  write sample
rd_bitrev  in  1  read order for the next frame (0 natural, 1 bit-reversed); sampled on frame_start
rd_data  out  DATA_W  read sample
rd_valid  out  1  rd_data belongs to a completely written frame
rd_first  out  1  rd_data is read index 0 of its frame
frame_start_out  out  1  frame_start delayed to align with rd_data
frame_err  out  1  sticky flag: a frame had a write count not equal to DEPTH

Behaviour:
- Reset (reset_n_c=0, asynchronous): all flops clear immediately; every output is 0. RAM contents are not reset.
- With en=0: no RAM write and no register update; all outputs hold.
- Every rule below applies only on a clock edge with en=1.
- wr_bank:
  - Reset value 0.
  - Toggles on frame_start.
  - Effective write bank wb = wr_bank XOR frame_start, so a write coincident with frame_start lands in the new bank.
  - Read bank rb = NOT wb.
- RAM write: when wr_valid=1, bank[wb][wr_addr] <= wr_data. Reads never target wb, so there is no read/write collision.
- rd_cnt (ADDR_W bits):
  - Is set to 0 on frame_start; otherwise increments, wrapping DEPTH-1 -> 0.
  - The effective index is 0 when frame_start=1, otherwise rd_cnt+1.
- mode_q: loads rd_bitrev on frame_start. The read address is the effective index, bit-reversed over ADDR_W bits when the active mode is 1 (rd_bitrev on a frame_start cycle, otherwise mode_q).
- Read latency: 1 enabled cycle. On the edge after index i is issued:
  - rd_data = bank[rb][addr(i)];
  - rd_first = (i==0);
  - frame_start_out = frame_start of the issuing cycle.
- rd_data is registered, not combinational.
- Validity tracking:
  - seen: set by the first frame_start.
  - full: set by any frame_start while seen=1.
  - rd_valid is a registered copy of full, aligned with rd_data.
  - Each flag is cleared only by reset.
- wr_cnt (ADDR_W+1 bits):
  - Counts wr_valid cycles per frame.
  - On frame_start with seen=1: if wr_cnt != DEPTH, set frame_err, which stays set until reset.
  - wr_cnt then restarts at wr_valid (0 or 1) for the coincident write.
- Frames longer than DEPTH wrap rd_cnt and re-read the bank. Extra writes overwrite addresses and are flagged via wr_cnt at the next frame_start.
- Back-to-back frame_start pulses: each toggles the bank and restarts counters. Two pulses in consecutive cycles are legal; they produce a 1-cycle frame plus frame_err.
- Reset mid-frame: outputs drop to 0 asynchronously. rd_valid stays 0 until two frame_start pulses have been seen.

Decomposition:
- Package cf_fft_pkg:
  - bitrev function, parametrised by width;
  - read-order constants ORDER_NATURAL=0 and ORDER_BITREV=1.
- Sub-module cf_fft_pp_bank:
  - one DEPTH x DATA_W RAM;
  - write port with enable, registered read port with enable;
  - instantiated twice. Bank-steering muxes stay in the top level.

Test Plan:
1. Bench DATA_W=32, ADDR_W=3. Assert reset_n_c=0 mid-cycle -> all outputs 0 without waiting for an edge. Release -> outputs stay 0 while idle.
2. Natural order:
   - Stimulus: frame A writes addr k = data 0x100+k, k=0..7, frame_start with k=0. Next frame_start, rd_bitrev=0.
   - Required: the following 8 cycles give rd_data 0x100..0x107, rd_valid=1, rd_first=1 only on 0x100, frame_start_out aligned with 0x100.
3. Bit-reversed: same writes with rd_bitrev=1 at the second frame_start -> rd_data sequence 0x100,0x104,0x102,0x106,0x101,0x105,0x103,0x107.
4. Concurrent operation: write frame B (0x200+k) while frame A is read -> A is read intact. At the next frame_start, B reads out in order with no gap cycle.
5. Enable gating: drop en for 3 cycles mid-read at 0x103 -> outputs hold 0x103. On resume, 0x104 follows with no duplicate or skip, and no writes occur during the stall.
6. Short frame: only 5 writes, then frame_start -> frame_err=1 from the next edge and stays set. A further reset clears it, and rd_valid returns only after two new frame_start pulses.
